// File: rtl/smallseg_g0_chain_ctrl.sv
// Hash-chain lookup controller: walks a linked list of table entries for a tuple,
// and interleaves single-cycle table writes between (never during) chain walks.
module smallseg_g0_chain_ctrl #(
   parameter int INDEX_BIT_LEN    = 11,
   parameter int PACKET_BIT_LEN   = 104,
   parameter int ENTRY_DATA_WIDTH = 60,
   parameter int MAX_HOPS         = 16,
   parameter int HOP_W            = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        srch_valid,
   output logic                        srch_ready,
   input  logic [PACKET_BIT_LEN-1:0]   srch_tuple,
   input  logic [INDEX_BIT_LEN-1:0]    srch_start,
   input  logic                        upd_valid,
   output logic                        upd_ready,
   input  logic [INDEX_BIT_LEN-1:0]    upd_addr,
   input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        res_hit,
   output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
   output logic [HOP_W-1:0]            res_hops,
   output logic [INDEX_BIT_LEN-1:0]    tbl_search_index,
   output logic [PACKET_BIT_LEN-1:0]   tbl_tupleData,
   output logic                        tbl_we,
   output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
   input  logic                        tbl_match,
   input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
   input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index
);

   typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WRITE, DONE} state_t;

   localparam logic GRANT_SEARCH = 1'b0;
   localparam logic GRANT_UPDATE = 1'b1;
   localparam logic [HOP_W-1:0] HOP_LIMIT = HOP_W'(MAX_HOPS);

   state_t                        state, state_next;
   logic                          last_grant;
   logic [PACKET_BIT_LEN-1:0]     tup_reg;
   logic [INDEX_BIT_LEN-1:0]      cur_index;
   logic [HOP_W-1:0]              hops;
   logic [INDEX_BIT_LEN-1:0]      upd_addr_reg;
   logic [ENTRY_DATA_WIDTH-1:0]   upd_data_reg;
   logic                          walk_end;

   // A walk ends on a hit, a null next pointer, or when the hop budget is spent.
   assign walk_end      = tbl_match || (tbl_next_index == '0) || (hops == HOP_LIMIT);
   assign tbl_tupleData = tup_reg;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next       = state;
      srch_ready       = 1'b0;
      upd_ready        = 1'b0;
      res_valid        = 1'b0;
      tbl_we           = 1'b0;
      tbl_search_index = '0;
      tbl_din          = '0;
      case (state)
         IDLE: begin
            if (!rst) begin
               // On a tie, the request type that lost last time wins.
               if (srch_valid && (!upd_valid || last_grant == GRANT_UPDATE)) begin
                  srch_ready = 1'b1;
                  state_next = LOOKUP;
               end else if (upd_valid) begin
                  upd_ready  = 1'b1;
                  state_next = WRITE;
               end
            end
         end
         LOOKUP: begin
            tbl_search_index = cur_index;
            state_next       = CHECK;
         end
         CHECK: begin
            state_next = walk_end ? DONE : LOOKUP;
         end
         WRITE: begin
            tbl_we           = 1'b1;
            tbl_search_index = upd_addr_reg;
            tbl_din          = upd_data_reg;
            state_next       = IDLE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant   <= GRANT_SEARCH;
         tup_reg      <= '0;
         cur_index    <= '0;
         hops         <= '0;
         upd_addr_reg <= '0;
         upd_data_reg <= '0;
         res_hit      <= 1'b0;
         res_ruleID   <= '0;
         res_hops     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (srch_ready) begin
                  last_grant <= GRANT_SEARCH;
                  tup_reg    <= srch_tuple;
                  cur_index  <= srch_start;
                  hops       <= '0;
               end else if (upd_ready) begin
                  last_grant   <= GRANT_UPDATE;
                  upd_addr_reg <= upd_addr;
                  upd_data_reg <= upd_data;
               end
            end
            LOOKUP: begin
               if (hops != HOP_LIMIT) hops <= hops + HOP_W'(1);
            end
            CHECK: begin
               if (tbl_match) begin
                  res_hit    <= 1'b1;
                  res_ruleID <= tbl_ruleID;
                  res_hops   <= hops;
               end else if (walk_end) begin
                  res_hit    <= 1'b0;
                  res_ruleID <= '0;
                  res_hops   <= hops;
               end else begin
                  cur_index <= tbl_next_index;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_smallseg_g0_chain_ctrl.sv
// Directed bench for the chain controller, with a behavioural table that
// registers its outputs one clock after the index is presented.
module tb_smallseg_g0_chain_ctrl;

   localparam int IW = 11;
   localparam int PW = 104;
   localparam int DW = 60;
   localparam int HW = 5;

   localparam logic [PW-1:0] T1 = 104'h1111_0000_0000_0000_0000_0001;
   localparam logic [PW-1:0] T2 = 104'h2222_0000_0000_0000_0000_0002;
   localparam logic [PW-1:0] T9 = 104'h9999_0000_0000_0000_0000_0009;
   localparam logic [PW-1:0] TX = 104'hDEAD_0000_0000_0000_0000_BEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          srch_valid, srch_ready;
   logic [PW-1:0] srch_tuple;
   logic [IW-1:0] srch_start;
   logic          upd_valid, upd_ready;
   logic [IW-1:0] upd_addr;
   logic [DW-1:0] upd_data;
   logic          res_valid, res_ready, res_hit;
   logic [IW-1:0] res_ruleID;
   logic [HW-1:0] res_hops;
   logic [IW-1:0] tbl_search_index;
   logic [PW-1:0] tbl_tupleData;
   logic          tbl_we;
   logic [DW-1:0] tbl_din;
   logic          tbl_match = 1'b0;
   logic [IW-1:0] tbl_ruleID = '0;
   logic [IW-1:0] tbl_next_index = '0;

   int errors = 0;
   int checks = 0;
   int we_count = 0;

   logic [PW-1:0] key_mem  [2048];
   logic [IW-1:0] rule_mem [2048];
   logic [IW-1:0] next_mem [2048];

   always #5 clk = ~clk;

   smallseg_g0_chain_ctrl dut (
      .clk(clk), .rst(rst),
      .srch_valid(srch_valid), .srch_ready(srch_ready),
      .srch_tuple(srch_tuple), .srch_start(srch_start),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_addr(upd_addr), .upd_data(upd_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_hit(res_hit), .res_ruleID(res_ruleID), .res_hops(res_hops),
      .tbl_search_index(tbl_search_index), .tbl_tupleData(tbl_tupleData),
      .tbl_we(tbl_we), .tbl_din(tbl_din),
      .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID), .tbl_next_index(tbl_next_index)
   );

   always @(posedge clk) begin
      tbl_match      <= (key_mem[tbl_search_index] != '0) && (key_mem[tbl_search_index] == tbl_tupleData);
      tbl_ruleID     <= rule_mem[tbl_search_index];
      tbl_next_index <= next_mem[tbl_search_index];
      if (tbl_we === 1'b1) we_count = we_count + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [IW-1:0] start;
      logic [PW-1:0] tup;
      logic          hit;
      logic [IW-1:0] rule;
      logic [HW-1:0] hops;
      int            lat;
   } vec_t;

   vec_t vecs[7];

   task automatic do_search(input int id, input vec_t v);
      int cnt;
      int we0;
      @(negedge clk);
      srch_valid = 1'b1; srch_start = v.start; srch_tuple = v.tup; res_ready = 1'b0;
      #1;
      cnt = 0;
      while (!srch_ready && cnt < 50) begin
         @(negedge clk); #1; cnt++;
      end
      chk($sformatf("v%0d_accept", id), srch_ready, 1'b1);
      we0 = we_count;
      @(posedge clk); #1;
      srch_valid = 1'b0;
      cnt = 1;
      while (!res_valid && cnt < 100) begin
         @(posedge clk); #1; cnt++;
      end
      chk($sformatf("v%0d_latency", id), cnt, v.lat);
      chk($sformatf("v%0d_hit", id), res_hit, v.hit);
      chk($sformatf("v%0d_ruleID", id), res_ruleID, v.rule);
      chk($sformatf("v%0d_hops", id), res_hops, v.hops);
      chk($sformatf("v%0d_no_write", id), we_count, we0);
      $display("search v%0d start=%0d hit=%0b rule=%0d hops=%0d latency=%0d",
               id, v.start, res_hit, res_ruleID, res_hops, cnt);
      @(negedge clk); res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
      chk($sformatf("v%0d_release", id), res_valid, 1'b0);
   endtask

   initial begin
      int bad;
      int w;
      logic [IW-1:0] r0;
      for (int i = 0; i < 2048; i++) begin
         key_mem[i] = '0; rule_mem[i] = '0; next_mem[i] = '0;
      end
      key_mem[5]  = T1; rule_mem[5]  = 11'd77;  next_mem[5]  = 11'd9;
      key_mem[9]  = T9; rule_mem[9]  = 11'd99;  next_mem[9]  = 11'd12;
      key_mem[12] = T2; rule_mem[12] = 11'd120; next_mem[12] = 11'd0;
      next_mem[3] = 11'd4; next_mem[4] = 11'd3;

      vecs[0] = '{start: 11'd5,  tup: T1, hit: 1'b1, rule: 11'd77,  hops: 5'd1,  lat: 3};
      vecs[1] = '{start: 11'd5,  tup: T2, hit: 1'b1, rule: 11'd120, hops: 5'd3,  lat: 7};
      vecs[2] = '{start: 11'd5,  tup: TX, hit: 1'b0, rule: 11'd0,   hops: 5'd3,  lat: 7};
      vecs[3] = '{start: 11'd3,  tup: TX, hit: 1'b0, rule: 11'd0,   hops: 5'd16, lat: 33};
      vecs[4] = '{start: 11'd9,  tup: T9, hit: 1'b1, rule: 11'd99,  hops: 5'd1,  lat: 3};
      vecs[5] = '{start: 11'd12, tup: T1, hit: 1'b0, rule: 11'd0,   hops: 5'd1,  lat: 3};
      vecs[6] = '{start: 11'd9,  tup: T2, hit: 1'b1, rule: 11'd120, hops: 5'd2,  lat: 5};

      // Reset with both requests already pending.
      rst = 1'b1; res_ready = 1'b0;
      srch_valid = 1'b1; srch_start = 11'd5; srch_tuple = T1;
      upd_valid = 1'b1; upd_addr = 11'd20; upd_data = 60'hABC_DEF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_srch_ready", srch_ready, 1'b0);
      chk("rst_upd_ready", upd_ready, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_hit", res_hit, 1'b0);
      chk("rst_res_ruleID", res_ruleID, '0);
      chk("rst_res_hops", res_hops, '0);
      chk("rst_tbl_we", tbl_we, 1'b0);
      chk("rst_tbl_index", tbl_search_index, '0);
      chk("rst_tbl_din", tbl_din, '0);
      chk("rst_tbl_tuple", tbl_tupleData, '0);

      // First tie after reset goes to the update.
      @(negedge clk); rst = 1'b0; #1;
      chk("tie1_upd_ready", upd_ready, 1'b1);
      chk("tie1_srch_ready", srch_ready, 1'b0);
      @(posedge clk); #1;
      chk("write_we", tbl_we, 1'b1);
      chk("write_index", tbl_search_index, 11'd20);
      chk("write_din", tbl_din, 60'hABC_DEF);
      chk("write_srch_ready", srch_ready, 1'b0);
      $display("update addr=20 we=%0b din=%0h", tbl_we, tbl_din);
      @(posedge clk); #1;
      chk("after_write_we", tbl_we, 1'b0);
      chk("after_write_din", tbl_din, '0);
      chk("tie2_srch_ready", srch_ready, 1'b1);
      chk("tie2_upd_ready", upd_ready, 1'b0);
      chk("write_pulses1", we_count, 1);
      @(posedge clk); #1;
      srch_valid = 1'b0;
      chk("lookup_index", tbl_search_index, 11'd5);
      chk("lookup_tuple", tbl_tupleData, T1);
      chk("lookup_upd_ready", upd_ready, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("tie_search_valid", res_valid, 1'b1);
      chk("tie_search_rule", res_ruleID, 11'd77);
      chk("tie_search_hops", res_hops, 5'd1);
      $display("search tie start=5 hit=%0b rule=%0d hops=%0d", res_hit, res_ruleID, res_hops);

      // Hold the result with both requesters pending.
      srch_valid = 1'b1;
      r0 = res_ruleID;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_ruleID !== r0 ||
             res_hops !== 5'd1 || srch_ready !== 1'b0 || upd_ready !== 1'b0)
            bad++;
      end
      chk("backpressure_stable", bad, 0);
      chk("backpressure_no_write", we_count, 1);
      @(negedge clk); res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
      chk("tie3_upd_ready", upd_ready, 1'b1);
      chk("tie3_srch_ready", srch_ready, 1'b0);
      @(posedge clk); #1;
      upd_valid = 1'b0;
      chk("write2_we", tbl_we, 1'b1);
      @(posedge clk); #1;
      chk("tie4_srch_ready", srch_ready, 1'b1);
      @(posedge clk); #1;
      srch_valid = 1'b0;
      chk("abort_in_lookup", tbl_search_index, 11'd5);

      // Reset during LOOKUP aborts the walk.
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_res_valid", res_valid, 1'b0);
      chk("abort_tbl_we", tbl_we, 1'b0);
      chk("abort_tbl_index", tbl_search_index, '0);
      @(negedge clk); rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b0 || tbl_we !== 1'b0) bad++;
      end
      chk("abort_quiet", bad, 0);
      w = we_count;
      chk("abort_write_pulses", w, 2);
      $display("abort reset during lookup res_valid=%0b writes=%0d", res_valid, w);

      for (int i = 0; i < 7; i++) do_search(i, vecs[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/smallseg_g0_chain_ctrl.md
SMALLSEG_G0_CHAIN_CTRL -- requirements
Module: smallseg_g0_chain_ctrl

Interface
REQ-001 The block SHALL have parameters: INDEX_BIT_LEN, default 11, table index width; PACKET_BIT_LEN, default 104, tuple width; ENTRY_DATA_WIDTH, default 60, table entry width; MAX_HOPS, default 16, chain walk limit; HOP_W, default 5, hop counter width.
REQ-002 Port list SHALL be: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-003 srch_valid  in  1  search request valid; srch_ready  out  1  search accepted when both high.
REQ-004 srch_tuple  in  PACKET_BIT_LEN  packet header tuple; srch_start  in  INDEX_BIT_LEN  chain head index.
REQ-005 upd_valid  in  1  update request valid; upd_ready  out  1  update accepted when both high.
REQ-006 upd_addr  in  INDEX_BIT_LEN  entry to write; upd_data  in  ENTRY_DATA_WIDTH  new entry contents.
REQ-007 res_valid  out  1  result valid; res_ready  in  1  result consumed when both high.
REQ-008 res_hit  out  1  rule found; res_ruleID  out  INDEX_BIT_LEN  matched rule; res_hops  out  HOP_W  lookups performed.
REQ-009 tbl_search_index  out  INDEX_BIT_LEN; tbl_tupleData  out  PACKET_BIT_LEN; tbl_we  out  1; tbl_din  out  ENTRY_DATA_WIDTH.
REQ-010 tbl_match  in  1; tbl_ruleID  in  INDEX_BIT_LEN; tbl_next_index  in  INDEX_BIT_LEN; all registered by the table one clk after tbl_search_index is presented.

Function
REQ-011 FSM states SHALL be IDLE, LOOKUP, CHECK, WRITE, DONE.
REQ-012 srch_ready and upd_ready SHALL only be high in IDLE, never both in the same cycle, and SHALL be low while rst is high.
REQ-013 Arbitration in IDLE: single requester granted directly; both valid -> grant the type not granted last; last_grant register resets to SEARCH, so the first tie grants the update.
REQ-014 Update accept (cycle C0): latch addr/data; C1 = WRITE with tbl_we=1, tbl_search_index=upd_addr, tbl_din=upd_data; C2 = IDLE.
REQ-015 tbl_we SHALL be high only in WRITE, exactly one cycle per accepted update.
REQ-016 Search accept (cycle C0): latch tuple into tup_reg, cur_index<=srch_start, hops<=0; next state LOOKUP.
REQ-017 LOOKUP: drive tbl_search_index=cur_index, tbl_tupleData=tup_reg; hops<=hops+1; next state CHECK.
REQ-018 CHECK: evaluate tbl outputs; tbl_match=1 -> res_hit=1, res_ruleID=tbl_ruleID, DONE.
REQ-019 CHECK, no match: tbl_next_index==0 (null pointer) or hops==MAX_HOPS -> res_hit=0, res_ruleID=0, DONE; otherwise cur_index<=tbl_next_index, LOOKUP.
REQ-020 Latency: hit on first hop -> res_valid high in C3; each additional hop adds 2 cycles.
REQ-021 DONE: res_valid=1 and result outputs stable until res_valid&res_ready; then IDLE next cycle.
REQ-022 tbl_we SHALL be 0 in LOOKUP/CHECK/DONE; no write ever interleaves a chain walk.
REQ-023 tbl_tupleData SHALL equal tup_reg in all states; tbl_din SHALL be 0 outside WRITE.
REQ-024 res_hops SHALL saturate at MAX_HOPS and never wrap.
REQ-025 Requests presented outside IDLE SHALL be held off by ready=0, not dropped or queued.

Reset
REQ-026 On rst: state=IDLE, last_grant=SEARCH, res_valid=0, res_hit=0, res_ruleID=0, res_hops=0, tbl_we=0, tbl_search_index=0, tbl_din=0, cur_index=0, tup_reg=0.
REQ-027 rst asserted mid-walk or mid-write SHALL abort the operation; no result and no further tbl_we pulse is produced.

Verification
REQ-028 Single hit: entry 5 matches tuple, srch_start=5 -> res_valid in C3, res_hit=1, res_ruleID=entry ruleID, res_hops=1.
REQ-029 Chain walk: 5->9->12, hit at 12 -> res_valid in C7, res_hops=3; miss with next=0 at 12 -> res_hit=0, res_hops=3.
REQ-030 Loop guard: 3->4->3 cycle, no match -> miss after MAX_HOPS=16 lookups, res_hops=16.
REQ-031 Contention: srch_valid and upd_valid together after reset -> update first (one tbl_we pulse to upd_addr), search granted next; repeated ties alternate.
REQ-032 Backpressure and reset: res_ready=0 for 10 cycles -> outputs stable, no new grant; rst during LOOKUP -> IDLE next cycle, res_valid=0, tbl_we=0.
